periph_bus_arbiter: RTL and testbench
=====================================

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, bus address width.
REQ-002 SHALL have parameter DW, default 32, bus data width.
REQ-003 SHALL have parameter RD_LAT, default 1, slave read latency in cycles (legal range 1..4).
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum consecutive locked M1 grants.
REQ-005 SHALL have port i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port i_rstn  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports i_m0_req / i_m1_req  in  1  transaction request (M0 = CPU, M1 = DMA).
REQ-008 SHALL have ports i_mN_we  in  1, i_mN_addr  in  AW, i_mN_wdata  in  DW (N = 0, 1); must be stable while req is high.
REQ-009 SHALL have port i_m1_lock  in  1  M1 burst lock request.
REQ-010 SHALL have ports o_mN_ack  out  1 (one-cycle completion pulse) and o_mN_rdata  out  DW (valid when ack is high on a read).
REQ-011 SHALL have ports o_bus_en  out  1, o_bus_we  out  1, o_bus_addr  out  AW, o_bus_wr_data  out  DW, i_bus_rd_data  in  DW (shared slave side).

Function
REQ-012 SHALL implement the FSM states IDLE, ACCESS, RDWAIT, RESP, all registered.
REQ-013 IDLE: with no req, SHALL stay in IDLE; otherwise SHALL pick a winner, latch its we/addr/wdata and go to ACCESS the next cycle.
REQ-014 Arbitration SHALL be round-robin: if both request, the master not served last wins; the last-served pointer resets to M1, so M0 wins the first tie.
REQ-015 Lock: if M1 was last served and i_m1_lock and i_m1_req are high, M1 SHALL win again, up to MAX_BURST consecutive grants; once the count reaches MAX_BURST and M0 requests, M0 SHALL win.
REQ-016 The burst counter SHALL clear whenever M0 is granted or i_m1_lock is low in IDLE.
REQ-017 ACCESS SHALL last exactly one cycle, with o_bus_en=1 and o_bus_we/addr/wr_data driven from the latched values.
REQ-018 For a write, ACCESS SHALL pulse the winner's o_mN_ack and then return to IDLE: write ack 1 cycle after req is sampled in IDLE.
REQ-019 For a read, ACCESS SHALL go to RDWAIT for RD_LAT-1 cycles, or directly to RESP when RD_LAT=1.
REQ-020 On entry to RESP, i_bus_rd_data SHALL be registered into the winner's o_mN_rdata, and ack SHALL pulse during RESP, then return to IDLE: read ack RD_LAT+1 cycles after the IDLE sample.
REQ-021 o_mN_rdata SHALL hold its value until the next read completion for that master.
REQ-022 Outside ACCESS, o_bus_en and o_bus_we SHALL be 0, and o_bus_addr/o_bus_wr_data SHALL hold their last values.
REQ-023 There SHALL be exactly one ack per transaction, never to both masters in the same cycle.
REQ-024 A req still high in the cycle after its ack SHALL be treated as a new transaction.
REQ-025 A requester that drops req before being granted SHALL be ignored, with no ack.
REQ-026 Changes to i_m1_lock SHALL affect only arbitration decisions in IDLE and never abort an in-flight transaction.

Reset
REQ-027 Asserting i_rstn low SHALL immediately force state IDLE, pointer M1 and burst count 0.
REQ-028 Reset SHALL drive all outputs to 0: o_mN_ack, o_mN_rdata, o_bus_en, o_bus_we, o_bus_addr, o_bus_wr_data.
REQ-029 A transaction in flight at reset SHALL be dropped without ack, and no bus strobe SHALL follow.
REQ-030 After reset release, the first IDLE sample SHALL occur on the first rising edge.

Structure
REQ-031 Package periph_bus_pkg SHALL hold the FSM state enum, the master-index typedef (M0/M1) and the default AW/DW constants.
REQ-032 The block SHALL be a single module with no sub-module; the round-robin pick is small enough to live inline.

Verification
REQ-033 M0 write, addr 0x05, data 0xA5, alone -> o_bus_en=1/we=1/addr 0x05 exactly one cycle, o_m0_ack 1 cycle after req sampled, M1 never acked.
REQ-034 M1 read, addr 0x10, slave returns 0x3C, RD_LAT=1 -> o_m1_ack 2 cycles after sample with o_m1_rdata=0x3C; repeat with RD_LAT=3 -> ack at 4 cycles.
REQ-035 M0 and M1 requesting continuously, writes, lock low -> grants alternate M0, M1, M0, M1 starting with M0.
REQ-036 M1 locked burst of 20 writes with M0 requesting from the start, MAX_BURST=16 -> 16 consecutive M1 acks, then an M0 ack, then M1 resumes.
REQ-037 i_rstn pulsed low during RDWAIT of an M0 read -> no o_m0_ack, all outputs 0, and the next request is served normally, M0 winning a tie.
REQ-038 M1 drops req before grant while M0 is active -> M1 receives no ack, and bus strobes match M0 transactions only.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared types and default widths for the two-master peripheral bus arbiter.
package periph_bus_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Master index: M0 is the CPU, M1 is the DMA engine.
  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } master_e;

endpackage

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter in front of a single peripheral slave. One transaction
// is in flight at a time: IDLE picks a winner, ACCESS strobes the bus for one
// cycle, reads then wait out the slave latency and return data in RESP.
// Ties are round-robin; M1 may hold the bus for a bounded locked burst.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_m0_req,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_wdata,
  output logic          o_m0_ack,
  output logic [DW-1:0] o_m0_rdata,
  input  logic          i_m1_req,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_wdata,
  input  logic          i_m1_lock,
  output logic          o_m1_ack,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_bus_en,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_wr_data,
  input  logic [DW-1:0] i_bus_rd_data
);

  // Burst counter must be able to hold MAX_BURST itself.
  localparam int unsigned   BW          = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX   = BW'(MAX_BURST);
  // RDWAIT lasts RD_LAT-1 cycles; the counter is loaded with that minus one.
  localparam int unsigned   WAIT_INIT_I = (RD_LAT > 1) ? RD_LAT - 2 : 0;
  localparam logic [1:0]    WAIT_INIT   = 2'(WAIT_INIT_I);

  state_e        state_q,       state_d;
  master_e       last_q,        last_d;
  master_e       owner_q,       owner_d;
  logic          txn_we_q,      txn_we_d;
  logic [1:0]    wait_q,        wait_d;
  logic [BW-1:0] burst_q,       burst_d;
  logic          bus_en_q,      bus_en_d;
  logic          bus_we_q,      bus_we_d;
  logic [AW-1:0] bus_addr_q,    bus_addr_d;
  logic [DW-1:0] bus_wr_data_q, bus_wr_data_d;
  logic          m0_ack_q,      m0_ack_d;
  logic          m1_ack_q,      m1_ack_d;
  logic [DW-1:0] m0_rdata_q,    m0_rdata_d;
  logic [DW-1:0] m1_rdata_q,    m1_rdata_d;

  master_e       winner;
  logic          m1_locked;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          capture;

  // Arbitration: locked M1 continuation first, then round-robin on ties.
  always_comb begin
    m1_locked = (last_q == MST_M1) && i_m1_lock && i_m1_req &&
                ((burst_q < BURST_MAX) || !i_m0_req);
    if (m1_locked) begin
      winner = MST_M1;
    end else if (i_m0_req && i_m1_req) begin
      winner = (last_q == MST_M1) ? MST_M0 : MST_M1;
    end else if (i_m1_req) begin
      winner = MST_M1;
    end else begin
      winner = MST_M0;
    end
    win_we    = (winner == MST_M1) ? i_m1_we    : i_m0_we;
    win_addr  = (winner == MST_M1) ? i_m1_addr  : i_m0_addr;
    win_wdata = (winner == MST_M1) ? i_m1_wdata : i_m0_wdata;
  end

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    txn_we_d      = txn_we_q;
    wait_d        = wait_q;
    burst_d       = burst_q;
    bus_en_d      = 1'b0;
    bus_we_d      = 1'b0;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    m0_ack_d      = 1'b0;
    m1_ack_d      = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    capture       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A dropped lock ends the burst even if nobody is requesting.
        if (!i_m1_lock) begin
          burst_d = '0;
        end
        if (i_m0_req || i_m1_req) begin
          owner_d       = winner;
          last_d        = winner;
          txn_we_d      = win_we;
          bus_en_d      = 1'b1;
          bus_we_d      = win_we;
          bus_addr_d    = win_addr;
          bus_wr_data_d = win_wdata;
          state_d       = ST_ACCESS;
          // Writes complete during the ACCESS cycle itself.
          if (win_we) begin
            if (winner == MST_M1) begin
              m1_ack_d = 1'b1;
            end else begin
              m0_ack_d = 1'b1;
            end
          end
          if (winner == MST_M0) begin
            burst_d = '0;
          end else if (i_m1_lock && (burst_q < BURST_MAX)) begin
            burst_d = burst_q + BW'(1);
          end
        end
      end

      ST_ACCESS: begin
        if (txn_we_q) begin
          state_d = ST_IDLE;
        end else if (RD_LAT == 1) begin
          state_d = ST_RESP;
          capture = 1'b1;
        end else begin
          state_d = ST_RDWAIT;
          wait_d  = WAIT_INIT;
        end
      end

      ST_RDWAIT: begin
        if (wait_q == 2'd0) begin
          state_d = ST_RESP;
          capture = 1'b1;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Slave data is taken on the edge that enters RESP, together with the ack.
    if (capture) begin
      if (owner_q == MST_M1) begin
        m1_rdata_d = i_bus_rd_data;
        m1_ack_d   = 1'b1;
      end else begin
        m0_rdata_d = i_bus_rd_data;
        m0_ack_d   = 1'b1;
      end
    end
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q       <= ST_IDLE;
      last_q        <= MST_M1;
      owner_q       <= MST_M0;
      txn_we_q      <= 1'b0;
      wait_q        <= 2'd0;
      burst_q       <= '0;
      bus_en_q      <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      txn_we_q      <= txn_we_d;
      wait_q        <= wait_d;
      burst_q       <= burst_d;
      bus_en_q      <= bus_en_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      m0_ack_q      <= m0_ack_d;
      m1_ack_q      <= m1_ack_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
    end
  end

  assign o_m0_ack      = m0_ack_q;
  assign o_m1_ack      = m1_ack_q;
  assign o_m0_rdata    = m0_rdata_q;
  assign o_m1_rdata    = m1_rdata_q;
  assign o_bus_en      = bus_en_q;
  assign o_bus_we      = bus_we_q;
  assign o_bus_addr    = bus_addr_q;
  assign o_bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: one instance with RD_LAT=1 and a
// second with RD_LAT=3 sharing the master buses but with private requests.
`timescale 1ns/1ps
module tb_periph_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic          mst;
    logic          rd;
    logic [DW-1:0] rdata;
    int            cyc;
  } ack_exp_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } bus_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rstn;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic          m0_req3, m1_req3;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, bus_rd_data;

  logic          a0, a1, ben, bwe;
  logic [DW-1:0] r0, r1, bwdata;
  logic [AW-1:0] baddr;
  logic          a0_3, a1_3, ben3, bwe3;
  logic [DW-1:0] r0_3, r1_3, bwdata3;
  logic [AW-1:0] baddr3;

  ack_exp_t ackq[$];
  ack_exp_t ackq3[$];
  bus_exp_t busq[$];

  int checks = 0;
  int errors = 0;

  periph_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_BURST(16)) u_dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_ack(a0), .o_m0_rdata(r0),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_lock(m1_lock), .o_m1_ack(a1), .o_m1_rdata(r1),
    .o_bus_en(ben), .o_bus_we(bwe), .o_bus_addr(baddr), .o_bus_wr_data(bwdata),
    .i_bus_rd_data(bus_rd_data)
  );

  periph_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .MAX_BURST(16)) u_dut3 (
    .i_clk(clk), .i_rstn(rstn),
    .i_m0_req(m0_req3), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_ack(a0_3), .o_m0_rdata(r0_3),
    .i_m1_req(m1_req3), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_lock(m1_lock), .o_m1_ack(a1_3), .o_m1_rdata(r1_3),
    .o_bus_en(ben3), .o_bus_we(bwe3), .o_bus_addr(baddr3), .o_bus_wr_data(bwdata3),
    .i_bus_rd_data(bus_rd_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic exp_ack(input logic m, input logic rd, input logic [DW-1:0] d, input int c);
    ack_exp_t e;
    e.mst = m; e.rd = rd; e.rdata = d; e.cyc = c;
    ackq.push_back(e);
  endtask

  task automatic exp_ack3(input logic m, input logic rd, input logic [DW-1:0] d, input int c);
    ack_exp_t e;
    e.mst = m; e.rd = rd; e.rdata = d; e.cyc = c;
    ackq3.push_back(e);
  endtask

  task automatic exp_bus(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd, input int c);
    bus_exp_t e;
    e.we = we; e.addr = ad; e.wdata = wd; e.cyc = c;
    busq.push_back(e);
  endtask

  // Write transaction from master_run: data is always address + 0x1000.
  task automatic exp_wr(input logic m, input logic [AW-1:0] ad, input int c);
    exp_bus(1'b1, ad, ad + 32'h1000, c);
    exp_ack(m, 1'b0, '0, c);
  endtask

  task automatic cmp_ack(input string nm, input ack_exp_t e, input logic m, input logic [DW-1:0] rd);
    checks++;
    if (m !== e.mst || cyc != e.cyc || (e.rd && rd !== e.rdata)) begin
      errors++;
      $display("FAIL %s: got m%0d at cycle %0d rdata %h, required m%0d at cycle %0d rdata %h",
               nm, m, cyc, rd, e.mst, e.cyc, e.rdata);
    end
  endtask

  // Monitor: pops and compares whenever either DUT presents an ack or strobe.
  task automatic monitor();
    bus_exp_t eb;
    forever begin
      @(negedge clk);
      if (a0 && a1) begin
        checks++; errors++;
        $display("FAIL dual_ack: both masters acked at cycle %0d, required at most one", cyc);
      end else if (a0 || a1) begin
        if (ackq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: m%0d acked at cycle %0d, required no ack", a1, cyc);
        end else begin
          cmp_ack("ack", ackq.pop_front(), a1, a1 ? r1 : r0);
        end
      end
      if (a0_3 && a1_3) begin
        checks++; errors++;
        $display("FAIL dual_ack3: both masters acked at cycle %0d, required at most one", cyc);
      end else if (a0_3 || a1_3) begin
        if (ackq3.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack3: m%0d acked at cycle %0d, required no ack", a1_3, cyc);
        end else begin
          cmp_ack("ack3", ackq3.pop_front(), a1_3, a1_3 ? r1_3 : r0_3);
        end
      end
      if (ben) begin
        checks++;
        if (busq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: addr %h at cycle %0d, required no strobe", baddr, cyc);
        end else begin
          eb = busq.pop_front();
          if (bwe !== eb.we || baddr !== eb.addr || bwdata !== eb.wdata || cyc != eb.cyc) begin
            errors++;
            $display("FAIL bus_strobe: got we=%0d addr=%h wdata=%h cycle %0d, required we=%0d addr=%h wdata=%h cycle %0d",
                     bwe, baddr, bwdata, cyc, eb.we, eb.addr, eb.wdata, eb.cyc);
          end
        end
      end
    end
  endtask

  // which: 0=dut m0, 1=dut m1, 2=dut3 m0, 3=dut3 m1
  task automatic wait_ack(input int which, input int limit, output bit ok);
    logic hit;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = a0;
        1: hit = a1;
        2: hit = a0_3;
        default: hit = a1_3;
      endcase
      if (hit) begin
        ok = 1'b1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL ack_timeout: port %0d got no ack in %0d cycles, required an ack", which, limit);
  endtask

  task automatic do_reset();
    m0_req = 1'b0; m1_req = 1'b0; m0_req3 = 1'b0; m1_req3 = 1'b0; m1_lock = 1'b0;
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Single transaction on u_dut, issued just after a rising edge.
  task automatic txn(input logic m, input logic we, input logic [AW-1:0] ad,
                     input logic [DW-1:0] wd, input logic [DW-1:0] rd_exp);
    int n;
    bit ok;
    n = cyc + 1;
    exp_bus(we, ad, wd, n);
    exp_ack(m, !we, rd_exp, we ? n : n + 1);
    if (m) begin m1_we = we; m1_addr = ad; m1_wdata = wd; m1_req = 1'b1; end
    else   begin m0_we = we; m0_addr = ad; m0_wdata = wd; m0_req = 1'b1; end
    wait_ack(m ? 1 : 0, 20, ok);
    if (m) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  // Master holding req high for cnt back-to-back writes on u_dut.
  task automatic master_run(input logic m, input int cnt, input logic [AW-1:0] base);
    bit ok;
    for (int i = 0; i < cnt; i++) begin
      if (m) begin m1_we = 1'b1; m1_addr = base + 32'(i); m1_wdata = base + 32'(i) + 32'h1000; m1_req = 1'b1; end
      else   begin m0_we = 1'b1; m0_addr = base + 32'(i); m0_wdata = base + 32'(i) + 32'h1000; m0_req = 1'b1; end
      wait_ack(m ? 1 : 0, 80, ok);
      if (!ok) break;
    end
    if (m) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  initial begin
    int  n;
    bit  ok;
    rstn = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
    m0_req3 = 1'b0; m1_req3 = 1'b0;
    bus_rd_data = 32'h3C;
    fork
      monitor();
    join_none

    // Reset state
    @(posedge clk); #1;
    chk("rst_m0_ack", 32'(a0), 32'd0);
    chk("rst_m1_ack", 32'(a1), 32'd0);
    chk("rst_m0_rdata", r0, 32'd0);
    chk("rst_m1_rdata", r1, 32'd0);
    chk("rst_bus_en", 32'(ben), 32'd0);
    chk("rst_bus_we", 32'(bwe), 32'd0);
    chk("rst_bus_addr", baddr, 32'd0);
    chk("rst_bus_wdata", bwdata, 32'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Lone M0 write, then bus side holds address/data but drops strobes
    txn(1'b0, 1'b1, 32'h05, 32'hA5, '0);
    @(posedge clk); #1;
    chk("idle_bus_en", 32'(ben), 32'd0);
    chk("idle_bus_we", 32'(bwe), 32'd0);
    chk("hold_bus_addr", baddr, 32'h05);
    chk("hold_bus_wdata", bwdata, 32'hA5);

    // M1 read with one-cycle slave, then a write must not disturb held rdata
    txn(1'b1, 1'b0, 32'h10, 32'h0, 32'h3C);
    @(posedge clk); #1;
    chk("m1_rdata_read", r1, 32'h3C);
    chk("m0_rdata_untouched", r0, 32'h0);
    txn(1'b1, 1'b1, 32'h20, 32'h77, '0);
    @(posedge clk); #1;
    chk("m1_rdata_hold", r1, 32'h3C);

    // M1 read on the three-cycle-latency instance
    m1_we = 1'b0; m1_addr = 32'h10; m1_wdata = '0;
    n = cyc + 1;
    exp_ack3(1'b1, 1'b1, 32'h3C, n + 3);
    m1_req3 = 1'b1;
    wait_ack(3, 20, ok);
    m1_req3 = 1'b0;
    @(posedge clk); #1;

    // Continuous contention without lock alternates starting with M0
    do_reset();
    n = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      exp_wr(1'b0, 32'h100 + 32'(k), n + 4 * k);
      exp_wr(1'b1, 32'h200 + 32'(k), n + 4 * k + 2);
    end
    fork
      master_run(1'b0, 3, 32'h100);
      master_run(1'b1, 3, 32'h200);
    join
    @(posedge clk); #1;

    // Locked M1 burst of 20 against a waiting M0
    do_reset();
    m1_lock = 1'b1;
    n = cyc + 1;
    for (int i = 0; i < 16; i++) exp_wr(1'b1, 32'h500 + 32'(i), n + 2 * i);
    exp_wr(1'b0, 32'h600, n + 32);
    for (int i = 16; i < 20; i++) exp_wr(1'b1, 32'h500 + 32'(i), n + 2 * i + 2);
    exp_wr(1'b0, 32'h601, n + 42);
    fork
      master_run(1'b1, 20, 32'h500);
      master_run(1'b0, 2, 32'h600);
    join
    m1_lock = 1'b0;
    @(posedge clk); #1;

    // Reset during RDWAIT of an M0 read on the slow instance
    do_reset();
    m0_we = 1'b0; m0_addr = 32'h44; m0_wdata = 32'h0;
    m0_req3 = 1'b1;
    @(posedge clk); #1;
    chk("rdwait_access_strobe", 32'(ben3), 32'd1);
    @(posedge clk); #1;
    chk("rdwait_no_strobe", 32'(ben3), 32'd0);
    rstn = 1'b0;
    m0_req3 = 1'b0;
    #1;
    chk("midrst_m0_ack", 32'(a0_3), 32'd0);
    chk("midrst_m1_ack", 32'(a1_3), 32'd0);
    chk("midrst_m0_rdata", r0_3, 32'd0);
    chk("midrst_m1_rdata", r1_3, 32'd0);
    chk("midrst_bus_en", 32'(ben3), 32'd0);
    chk("midrst_bus_we", 32'(bwe3), 32'd0);
    chk("midrst_bus_addr", baddr3, 32'd0);
    chk("midrst_bus_wdata", bwdata3, 32'd0);
    @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("postrst_no_strobe", 32'(ben3), 32'd0);
    end
    m0_we = 1'b1; m0_addr = 32'h50; m0_wdata = 32'h51;
    m1_we = 1'b1; m1_addr = 32'h60; m1_wdata = 32'h61;
    n = cyc + 1;
    exp_ack3(1'b0, 1'b0, '0, n);
    exp_ack3(1'b1, 1'b0, '0, n + 2);
    m0_req3 = 1'b1; m1_req3 = 1'b1;
    wait_ack(2, 20, ok);
    m0_req3 = 1'b0;
    wait_ack(3, 20, ok);
    m1_req3 = 1'b0;
    @(posedge clk); #1;

    // M1 pulses req only while M0 owns the bus and withdraws before a sample
    do_reset();
    n = cyc + 1;
    exp_wr(1'b0, 32'h400, n);
    exp_wr(1'b0, 32'h401, n + 2);
    fork
      master_run(1'b0, 2, 32'h400);
      begin
        @(posedge clk); #1;
        m1_we = 1'b1; m1_addr = 32'h99; m1_wdata = 32'h99; m1_req = 1'b1;
        @(posedge clk); #1;
        m1_req = 1'b0;
      end
    join

    repeat (6) @(posedge clk);
    #1;
    chk("ackq_drained", 32'(ackq.size()), 32'd0);
    chk("ackq3_drained", 32'(ackq3.size()), 32'd0);
    chk("busq_drained", 32'(busq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
